fetch_unit: RTL
===============

# fetch_unit

Front-end instruction fetch stage: owns the architectural fetch PC, issues in-order 32-bit instruction requests to instruction memory over a valid/ready port, and buffers returned words with their PCs in a small FIFO. It produces the `pc`/`instr` pair consumed by the static decoder. Branch and trap redirects flush all younger state and discard in-flight responses.

## Interface
- `RESET_PC`, default `64'h8000_0000`: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 4: FIFO entries; also the cap on FIFO occupancy plus all in-flight requests. Power of two, at least 2.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `redirect_valid_i` in 1: flush and restart fetch at `redirect_pc_i`.
- `redirect_pc_i` in `C::XLEN`: new fetch PC; bits [1:0] ignored and treated as 0.
- `imem_req_valid_o` out 1: request valid.
- `imem_req_ready_i` in 1: memory accepts the request.
- `imem_req_addr_o` out `C::XLEN`: word-aligned fetch address.
- `imem_rsp_valid_i` in 1: response valid. Responses return in request order, with no backpressure.
- `imem_rsp_data_i` in 32: instruction word.
- `imem_rsp_err_i` in 1: access fault for this word.
- `fetch_valid_o` out 1: the head entry is valid toward the decoder.
- `fetch_ready_i` in 1: the decoder consumes the head entry.
- `fetch_pc_o` out `C::XLEN`: PC of the head entry.
- `fetch_instr_o` out 32: instruction of the head entry.
- `fetch_err_o` out 1: access fault on the head entry.

## Operation
- State `req_pc` is the next address to request.
- State `rsp_pc` is the PC of the next expected live response.
- Counter `inflight` holds live outstanding requests. Counter `drop` holds outstanding requests whose responses are to be discarded.
- FSM has three states: IDLE, RUN, HALT.
  - IDLE is the reset state. It moves to RUN unconditionally on the first clock edge after reset is released.
  - RUN moves to HALT when a live response with `imem_rsp_err_i`=1 is enqueued.
  - HALT moves to RUN on `redirect_valid_i`. A redirect in RUN stays in RUN.
- Request issue:
  - `imem_req_valid_o` = (state==RUN) && (occupancy + `inflight` + `drop` < `DEPTH`).
  - `imem_req_addr_o` = `req_pc`.
  - On handshake: `req_pc` += 4 (wraps mod 2^XLEN) and `inflight` += 1.
- Response:
  - If `drop`>0, the response is discarded and `drop` -= 1.
  - Otherwise the entry {`rsp_pc`, data, err} is enqueued, `rsp_pc` += 4 and `inflight` -= 1.
  - Because credits are checked at issue, the FIFO never overflows.
- Fault: when a live response has err=1, it is enqueued with err set. In the same cycle `drop` += remaining `inflight` (excluding this response) and `inflight` is cleared. No further requests issue until a redirect.
- Redirect (highest priority):
  - FIFO is flushed.
  - `req_pc` and `rsp_pc` are set to `redirect_pc_i`.
  - `drop` is set to `drop` + `inflight` + (request handshake this cycle) − (response arriving this cycle).
  - `inflight` is set to 0.
  - A `fetch_ready_i` handshake in the same cycle is void. The decoder side flushes on the same redirect.
- Output: `fetch_*_o` show the FIFO head, with `fetch_valid_o` = FIFO not empty. A pop and an enqueue in the same cycle are both honoured when the FIFO is full.

## Timing
- Reset values:
  - `imem_req_valid_o`=0, `fetch_valid_o`=0, `fetch_pc_o`=0, `fetch_instr_o`=0, `fetch_err_o`=0, `imem_req_addr_o`=`RESET_PC`.
  - All counters are 0 and the FIFO is empty.
- The first request is visible 1 cycle after reset is released, when the FSM enters RUN.
- Response to fetch output latency is 1 cycle: a response enqueued at edge N is visible after edge N.
- After a redirect at edge N, the request at the new PC is visible in the cycle following N, provided a credit is free.
- Reset asserted mid-operation clears all state immediately. Responses that arrive for pre-reset requests are not tracked; the memory side is reset together with this block.

## Structure
- Add `C::fetch_entry_t` {pc `XLEN`, instr 32, err 1} and `C::fetch_state_e` {FS_IDLE, FS_RUN, FS_HALT} to the shared package C.
- Use one sub-module, `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, `DEPTH` entries, with push, pop, flush, full, empty and count ports, async active-high reset.

## Test plan
- Reset with `RESET_PC`=0x8000_0000 and single-cycle-latency memory -> requests go to 0x8000_0000, 0x…04, 0x…08, …; the decoder sees matching PC and instruction pairs in order, one per cycle when `fetch_ready_i`=1.
- Hold `fetch_ready_i`=0 with `DEPTH`=4 -> exactly 4 requests are issued, then `imem_req_valid_o`=0. Releasing ready for 1 cycle allows exactly one new request.
- Issue 3 requests at 0x8000_0000, 0x…04, 0x…08, then redirect to 0x8000_1000 before any response arrives -> the 3 old responses are dropped; the first `fetch_pc_o` is 0x8000_1000.
- Redirect in the same cycle as a request handshake and a response arrival -> `drop` is computed correctly, and no stale PC ever reaches the fetch output.
- Return err=1 on 0x8000_0008 with 2 more requests in flight -> that entry is output with `fetch_err_o`=1, the next 2 responses are dropped, the FSM is in HALT with no requests, and a redirect to 0x200 resumes fetch.
- Redirect to 0xFFFF_FFFF_FFFF_FFFC -> the next request addresses are 0xFFFF_FFFF_FFFF_FFFC then 0x0; `redirect_pc_i`=0x…103 produces a request to 0x…100.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared front-end package: architectural width, fetch FIFO entry and fetch FSM states.
package C;

  localparam int XLEN = 64;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            err;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port and decoder-facing fetch port of the fetch stage.
interface fetch_unit_if;
  import C::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;
  logic [31:0]     fetch_instr;
  logic            fetch_err;

  modport master (
    output imem_req_valid, imem_req_addr, fetch_valid, fetch_pc, fetch_instr, fetch_err,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, fetch_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, fetch_valid, fetch_pc, fetch_instr, fetch_err,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, fetch_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; push while full is accepted only alongside a pop.
module fetch_fifo
  import C::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  fetch_entry_t             din,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    cnt;
    logic           do_push, do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: storage has no reset; an entry is only ever read after it was written, and the
    // top masks the head while empty, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited imem requests, buffers returned words.
module fetch_unit
  import C::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    fetch_unit_if.master     bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    fetch_state_e    state;
    logic [XLEN-1:0] req_pc, rsp_pc, new_pc;
    logic [CW-1:0]   inflight, drop, occ;
    logic [SW-1:0]   credit_used;
    logic            req_fire, rsp_live, rsp_tracked, push, pop;
    logic            fifo_full, fifo_empty;
    fetch_entry_t    din, head;

    // Every slot a response could land in is reserved at issue time, dropped ones included.
    assign credit_used = SW'(occ) + SW'(inflight) + SW'(drop);
    assign bus.imem_req_valid = (state == FS_RUN) && (credit_used < SW'(DEPTH));
    assign bus.imem_req_addr  = req_pc;
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

    // Responses with nothing outstanding belong to requests issued before the last reset.
    assign rsp_tracked = bus.imem_rsp_valid && ((drop != '0) || (inflight != '0));
    assign rsp_live    = bus.imem_rsp_valid && (drop == '0) && (inflight != '0);
    assign new_pc      = redirect_pc_i & ~XLEN'(3);

    assign din  = '{pc: rsp_pc, instr: bus.imem_rsp_data, err: bus.imem_rsp_err};
    assign pop  = !fifo_empty && bus.fetch_ready && !redirect_valid_i;
    assign push = rsp_live && !redirect_valid_i && (!fifo_full || pop);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .flush (redirect_valid_i),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occ),
        .head  (head)
    );

    assign bus.fetch_valid = !fifo_empty;
    assign bus.fetch_pc    = fifo_empty ? '0 : head.pc;
    assign bus.fetch_instr = fifo_empty ? '0 : head.instr;
    assign bus.fetch_err   = fifo_empty ? 1'b0 : head.err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= FS_IDLE;
            req_pc   <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else if (redirect_valid_i) begin
            state    <= FS_RUN;
            req_pc   <= new_pc;
            rsp_pc   <= new_pc;
            inflight <= '0;
            drop     <= drop + inflight + CW'(req_fire) - CW'(rsp_tracked);
        end else begin
            if (state == FS_IDLE) state <= FS_RUN;
            if (req_fire) req_pc <= req_pc + XLEN'(4);

            if (bus.imem_rsp_valid && (drop != '0)) begin
                drop     <= drop - CW'(1);
                inflight <= inflight + CW'(req_fire);
            end else if (rsp_live) begin
                rsp_pc <= rsp_pc + XLEN'(4);
                if (bus.imem_rsp_err) begin
                    // Everything still outstanding after the faulting word is now dead.
                    drop     <= inflight - CW'(1) + CW'(req_fire);
                    inflight <= '0;
                    state    <= FS_HALT;
                end else begin
                    inflight <= inflight + CW'(req_fire) - CW'(1);
                end
            end else begin
                inflight <= inflight + CW'(req_fire);
            end
        end
    end

endmodule
